// File: rtl/riscy_phase_sequencer.sv
// RISCY instruction sequencer: steps each instruction through FETCH, DECODE,
// EXECUTE and UPDATE (one clock per phase) and decodes OPCODE/IFLAG/flags into
// per-phase datapath enables. Also owns run/idle/halt control and a
// retired-instruction counter.
//
// Opcode map (OPW=4): 0 NOP, 1 LDA, 2 LDB, 3-8 ALU ops, 9 JMP, A JZ, B JC,
// C IN, D OUT, E DIR, F HLT.
module riscy_phase_sequencer #(
  parameter int OPW   = 4,
  parameter int ICNTW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic [OPW-1:0]   OPCODE,
  input  logic             IFLAG,
  input  logic             ZF,
  input  logic             CF,
  output logic             IR_EN,
  output logic             RAM_CS,
  output logic             RAM_RD,
  output logic             RAM_WS,
  output logic             RDR_EN,
  output logic             MUX_SEL,
  output logic             A_EN,
  output logic             B_EN,
  output logic             ALU_EN,
  output logic             ALU_OE,
  output logic             PORT_EN,
  output logic             PDR_EN,
  output logic             PORT_RD,
  output logic             PC_EN,
  output logic             PC_LOAD,
  output logic [1:0]       PHASE,
  output logic             BUSY,
  output logic             HALTED,
  output logic [ICNTW-1:0] ICOUNT
);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic op_nop, op_lda, op_ldb, op_alu, op_jmp, op_jz, op_jc;
  logic op_in, op_out, op_dir, op_hlt, needs_operand;

  // Opcode classification shared by the next-state and output decode.
  always_comb begin
    op_nop        = (OPCODE == OPW'(0));
    op_lda        = (OPCODE == OPW'(1));
    op_ldb        = (OPCODE == OPW'(2));
    op_alu        = (OPCODE >= OPW'(3)) && (OPCODE <= OPW'(8));
    op_jmp        = (OPCODE == OPW'(9));
    op_jz         = (OPCODE == OPW'(10));
    op_jc         = (OPCODE == OPW'(11));
    op_in         = (OPCODE == OPW'(12));
    op_out        = (OPCODE == OPW'(13));
    op_dir        = (OPCODE == OPW'(14));
    op_hlt        = (OPCODE == OPW'(15));
    needs_operand = op_lda | op_ldb | op_out | op_dir;
  end

  // State register; reset forces RESET so every decoded enable drops at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_RESET;
    else     state <= state_nxt;
  end

  // Retired-instruction counter: advances on every edge that leaves UPDATE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    ICOUNT <= '0;
    else if (state == S_UPDATE) ICOUNT <= ICOUNT + ICNTW'(1);
  end

  // Next-state logic and Moore-style output decode.
  always_comb begin
    state_nxt = state;
    IR_EN     = 1'b0;
    RAM_CS    = 1'b0;
    RAM_RD    = 1'b0;
    RAM_WS    = 1'b0;
    RDR_EN    = 1'b0;
    MUX_SEL   = 1'b0;
    A_EN      = 1'b0;
    B_EN      = 1'b0;
    ALU_EN    = 1'b0;
    ALU_OE    = 1'b0;
    PORT_EN   = 1'b0;
    PDR_EN    = 1'b0;
    PORT_RD   = 1'b0;
    PC_EN     = 1'b0;
    PC_LOAD   = 1'b0;
    PHASE     = 2'd0;
    BUSY      = 1'b0;
    HALTED    = 1'b0;

    unique case (state)
      S_RESET: state_nxt = S_IDLE;
      S_IDLE:  if (RUN) state_nxt = S_FETCH;
      S_FETCH: begin
        state_nxt = S_DECODE;
        BUSY      = 1'b1;
        PHASE     = 2'd0;
        IR_EN     = 1'b1;
      end
      S_DECODE: begin
        state_nxt = S_EXECUTE;
        BUSY      = 1'b1;
        PHASE     = 2'd1;
        if (needs_operand && !IFLAG) begin
          RAM_CS = 1'b1;
          RAM_RD = 1'b1;
          RDR_EN = 1'b1;
        end
      end
      S_EXECUTE: begin
        state_nxt = S_UPDATE;
        BUSY      = 1'b1;
        PHASE     = 2'd2;
        MUX_SEL   = ~IFLAG;
        A_EN      = op_lda;
        B_EN      = op_ldb;
        ALU_EN    = op_alu;
        PORT_EN   = op_out;
        PDR_EN    = op_dir;
      end
      S_UPDATE: begin
        BUSY    = 1'b1;
        PHASE   = 2'd3;
        PC_EN   = ~op_hlt;
        // Only one bus driver per instruction: ALU result or port pins.
        ALU_OE  = op_alu;
        PORT_RD = op_in;
        RAM_CS  = op_alu | op_in;
        RAM_WS  = op_alu | op_in;
        PC_LOAD = op_jmp | (op_jz & ZF) | (op_jc & CF) | (op_nop & 1'b0);
        if (op_hlt)   state_nxt = S_HALT;
        else if (RUN) state_nxt = S_FETCH;
        else          state_nxt = S_IDLE;
      end
      S_HALT: HALTED = 1'b1;
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_riscy_phase_sequencer.sv
// Self-checking bench for riscy_phase_sequencer (ICNTW=4 so the counter wrap
// is reachable). A behavioural model tracks mode/phase/count and derives the
// expected enables directly from the per-phase instruction rules.
module tb_riscy_phase_sequencer;

  logic       clk = 1'b0;
  logic       RST, RUN, IFLAG, ZF, CF;
  logic [3:0] OPCODE;
  logic       IR_EN, RAM_CS, RAM_RD, RAM_WS, RDR_EN, MUX_SEL, A_EN, B_EN;
  logic       ALU_EN, ALU_OE, PORT_EN, PDR_EN, PORT_RD, PC_EN, PC_LOAD;
  logic [1:0] PHASE;
  logic       BUSY, HALTED;
  logic [3:0] ICOUNT;

  riscy_phase_sequencer #(.OPW(4), .ICNTW(4)) dut (
    .CLK(clk), .RST(RST), .RUN(RUN), .OPCODE(OPCODE), .IFLAG(IFLAG),
    .ZF(ZF), .CF(CF), .IR_EN(IR_EN), .RAM_CS(RAM_CS), .RAM_RD(RAM_RD),
    .RAM_WS(RAM_WS), .RDR_EN(RDR_EN), .MUX_SEL(MUX_SEL), .A_EN(A_EN),
    .B_EN(B_EN), .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .PORT_EN(PORT_EN),
    .PDR_EN(PDR_EN), .PORT_RD(PORT_RD), .PC_EN(PC_EN), .PC_LOAD(PC_LOAD),
    .PHASE(PHASE), .BUSY(BUSY), .HALTED(HALTED), .ICOUNT(ICOUNT)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {IR_EN, RAM_CS, RAM_RD, RAM_WS, RDR_EN, MUX_SEL, A_EN, B_EN,
                ALU_EN, ALU_OE, PORT_EN, PDR_EN, PORT_RD, PC_EN, PC_LOAD,
                PHASE, BUSY, HALTED};

  localparam int M_RESET = 0, M_IDLE = 1, M_BUSY = 2, M_HALT = 3;
  int m_mode, m_phase, m_icount;
  int vectors = 0, errors = 0;

  // Expected outputs from the instruction rules for the current model phase.
  function automatic logic [18:0] model_outs();
    logic ir, cs, rd, ws, rdr, mux, a, b, alu, oe, pen, pdr, prd, pce, pcl;
    logic [1:0] ph;
    logic busy, halt;
    int op;
    {ir, cs, rd, ws, rdr, mux, a, b, alu, oe, pen, pdr, prd, pce, pcl} = '0;
    ph = 2'd0; busy = 1'b0;
    op = int'(OPCODE);
    halt = (m_mode == M_HALT);
    if (m_mode == M_BUSY) begin
      busy = 1'b1;
      ph = 2'(m_phase);
      case (m_phase)
        0: ir = 1'b1;
        1: if ((op == 1 || op == 2 || op == 13 || op == 14) && !IFLAG) begin
             cs = 1'b1; rd = 1'b1; rdr = 1'b1;
           end
        2: begin
             mux = ~IFLAG;
             a   = (op == 1);
             b   = (op == 2);
             alu = (op >= 3 && op <= 8);
             pen = (op == 13);
             pdr = (op == 14);
           end
        default: begin
             pce = (op != 15);
             if (op >= 3 && op <= 8) begin oe = 1'b1; cs = 1'b1; ws = 1'b1; end
             if (op == 12) begin prd = 1'b1; cs = 1'b1; ws = 1'b1; end
             pcl = (op == 9) || (op == 10 && ZF) || (op == 11 && CF);
           end
      endcase
    end
    return {ir, cs, rd, ws, rdr, mux, a, b, alu, oe, pen, pdr, prd, pce, pcl,
            ph, busy, halt};
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_advance();
    if (RST) begin
      m_mode = M_RESET; m_icount = 0;
    end else begin
      case (m_mode)
        M_RESET: m_mode = M_IDLE;
        M_IDLE:  if (RUN) begin m_mode = M_BUSY; m_phase = 0; end
        M_BUSY:
          if (m_phase < 3) m_phase++;
          else begin
            m_icount = (m_icount + 1) % 16;
            if (OPCODE == 4'd15) m_mode = M_HALT;
            else if (RUN)        m_phase = 0;
            else                 m_mode = M_IDLE;
          end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_init();
    RST = 1'b1; RUN = 1'b0; OPCODE = '0; IFLAG = 1'b0; ZF = 1'b0; CF = 1'b0;
    m_mode = M_RESET; m_phase = 0; m_icount = 0;
    #3;
    vectors++;
    if (obs !== 19'd0 || ICOUNT !== 4'd0) begin
      errors++;
      $display("FAIL reset_init: got %h/%0d want 0/0", obs, ICOUNT);
    end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      vectors++;
      if (obs !== model_outs() || ICOUNT !== 4'(m_icount)) begin
        errors++;
        $display("FAIL reset_release c%0d: got %h/%0d want %h/%0d", i, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
  endtask

  task automatic test_lda();
    RUN = 1'b1; OPCODE = 4'd1; IFLAG = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) RUN = 1'b0;
      #2;
      vectors++;
      if (obs !== model_outs() || ICOUNT !== 4'(m_icount)) begin
        errors++;
        $display("FAIL lda c%0d: got %h/%0d want %h/%0d", i, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
    vectors++;
    if (ICOUNT !== 4'd1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL lda_count: got icount %0d busy %b want 1 0", ICOUNT, BUSY);
    end
  endtask

  task automatic test_add();
    RUN = 1'b1; OPCODE = 4'd3; IFLAG = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) RUN = 1'b0;
      #2;
      vectors++;
      if (obs !== model_outs() || (ALU_OE && RAM_RD) || ICOUNT !== 4'(m_icount)) begin
        errors++;
        $display("FAIL add c%0d: got %h/%0d want %h/%0d", i, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
  endtask

  task automatic test_jz();
    RUN = 1'b1; OPCODE = 4'd10; IFLAG = 1'b1; ZF = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) ZF = 1'b1;
      if (i == 8) RUN = 1'b0;
      #2;
      vectors++;
      if (obs !== model_outs() || ICOUNT !== 4'(m_icount)) begin
        errors++;
        $display("FAIL jz c%0d: got %h/%0d want %h/%0d", i, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    RUN = 1'b1; OPCODE = 4'd3; IFLAG = 1'b0;
    for (int i = 0; i < 3; i++) tick();  // IDLE -> FETCH -> DECODE -> EXECUTE
    #1;
    RST = 1'b1;
    m_mode = M_RESET; m_icount = 0;
    #1;
    vectors++;
    if (obs !== 19'd0 || ICOUNT !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%0d want 0/0", obs, ICOUNT);
    end
    tick();
    RST = 1'b0; RUN = 1'b0;
    tick();
    #2;
    vectors++;
    if (obs !== model_outs() || BUSY !== 1'b0 || ICOUNT !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h/%0d want %h/0", obs, ICOUNT, model_outs());
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == M_IDLE || (m_mode == M_BUSY && m_phase == 0)) begin
        OPCODE = 4'($urandom_range(0, 14));
        IFLAG  = 1'($urandom_range(0, 1));
      end
      ZF  = 1'($urandom_range(0, 1));
      CF  = 1'($urandom_range(0, 1));
      RUN = ($urandom_range(0, 7) != 0);
      #2;
      vectors++;
      if (obs !== model_outs() || ICOUNT !== 4'(m_icount)
          || (int'(ALU_OE) + int'(PORT_RD) + int'(RAM_RD)) > 1) begin
        errors++;
        $display("FAIL random c%0d op%0d: got %h/%0d want %h/%0d", i, OPCODE, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int fetches = 0;
    RST = 1'b1; RUN = 1'b0;
    tick();
    RST = 1'b0; RUN = 1'b1; OPCODE = 4'd0; IFLAG = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (i == 68) RUN = 1'b0;  // EXECUTE of the 17th NOP
      #2;
      if (IR_EN) fetches++;
      vectors++;
      if (obs !== model_outs() || ICOUNT !== 4'(m_icount)) begin
        errors++;
        $display("FAIL wrap c%0d: got %h/%0d want %h/%0d", i, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
    #2;
    vectors++;
    if (ICOUNT !== 4'd1 || BUSY !== 1'b0 || fetches != 17) begin
      errors++;
      $display("FAIL wrap_end: got icount %0d busy %b fetches %0d want 1 0 17", ICOUNT, BUSY, fetches);
    end
    tick();
  endtask

  task automatic test_halt();
    int start, fetches = 0;
    start = m_icount;
    RUN = 1'b1; OPCODE = 4'd15; IFLAG = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i >= 5) begin
        RUN    = 1'($urandom_range(0, 1));
        OPCODE = 4'($urandom_range(0, 15));
        if (IR_EN) fetches++;
      end
      #2;
      vectors++;
      if (obs !== model_outs() || ICOUNT !== 4'(m_icount)) begin
        errors++;
        $display("FAIL halt c%0d: got %h/%0d want %h/%0d", i, obs, ICOUNT, model_outs(), m_icount);
      end
      tick();
    end
    vectors++;
    if (HALTED !== 1'b1 || PHASE !== 2'd0 || fetches != 0 || ICOUNT !== 4'((start + 1) % 16)) begin
      errors++;
      $display("FAIL halt_end: got halted %b phase %0d fetches %0d icount %0d want 1 0 0 %0d",
               HALTED, PHASE, fetches, ICOUNT, (start + 1) % 16);
    end
  endtask

  initial begin
    test_reset_init();
    test_lda();
    test_add();
    test_jz();
    test_reset_mid();
    test_random();
    test_wrap();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
